// File: rtl/mini_src_ctrl_pkg.sv
// Shared constants for the Mini-SRC control sequencer: opcodes, state codes, ctrl bit map,
// instruction classes and the per-class final execute step.
package mini_src_ctrl_pkg;

    localparam int unsigned CtrlWidth = 32;
    localparam int unsigned OpWidth   = 5;

    localparam logic [4:0] OpLd   = 5'b00000, OpLdi  = 5'b00001, OpSt   = 5'b00010;
    localparam logic [4:0] OpAdd  = 5'b00011, OpSub  = 5'b00100, OpAnd  = 5'b00101;
    localparam logic [4:0] OpOr   = 5'b00110, OpShr  = 5'b00111, OpShra = 5'b01000;
    localparam logic [4:0] OpShl  = 5'b01001, OpRor  = 5'b01010, OpRol  = 5'b01011;
    localparam logic [4:0] OpAddi = 5'b01100, OpAndi = 5'b01101, OpOri  = 5'b01110;
    localparam logic [4:0] OpMul  = 5'b01111, OpDiv  = 5'b10000, OpNeg  = 5'b10001;
    localparam logic [4:0] OpNot  = 5'b10010, OpBr   = 5'b10011, OpJr   = 5'b10100;
    localparam logic [4:0] OpJal  = 5'b10101, OpIn   = 5'b10110, OpOut  = 5'b10111;
    localparam logic [4:0] OpMfhi = 5'b11000, OpMflo = 5'b11001, OpNop  = 5'b11010;
    localparam logic [4:0] OpHalt = 5'b11011;

    localparam logic [3:0] StRst = 4'b0000, StT0 = 4'b0111, StT1 = 4'b1000, StT2 = 4'b1001;
    localparam logic [3:0] StT3  = 4'b1010, StT4 = 4'b1011, StT5 = 4'b1100, StT6 = 4'b1101;
    localparam logic [3:0] StT7  = 4'b1110, StHalt = 4'b1111;

    localparam int unsigned CPcOut     = 0,  CMarIn     = 1,  CIncPc    = 2,  CPcIn      = 3;
    localparam int unsigned CRead      = 4,  CMdrIn     = 5,  CMdrOut   = 6,  CIrIn      = 7;
    localparam int unsigned CGra       = 8,  CGrb       = 9,  CGrc      = 10, CRin       = 11;
    localparam int unsigned CRout      = 12, CBaOut     = 13, CCout     = 14, CYin       = 15;
    localparam int unsigned CZlowIn    = 16, CZhighIn   = 17, CZlowOut  = 18, CZhighOut  = 19;
    localparam int unsigned CLoIn      = 20, CHiIn      = 21, CLoOut    = 22, CHiOut     = 23;
    localparam int unsigned CConIn     = 24, CJalFlag   = 25, CInPortOut = 26, COutPortIn = 27;
    localparam int unsigned CWrite     = 28;

    // Every strobe that puts a value on the shared bus; at most one may be active per state.
    localparam logic [CtrlWidth-1:0] BusDrivers =
        (32'd1 << CPcOut) | (32'd1 << CMdrOut) | (32'd1 << CRout) | (32'd1 << CBaOut) |
        (32'd1 << CCout) | (32'd1 << CZlowOut) | (32'd1 << CZhighOut) | (32'd1 << CLoOut) |
        (32'd1 << CHiOut) | (32'd1 << CInPortOut);

    typedef enum logic [3:0] {
        ClsR, ClsI, ClsUn, ClsMd, ClsLd, ClsLdi, ClsSt, ClsBr, ClsJ, ClsIo, ClsMv, ClsNop, ClsHlt
    } op_class_e;

    function automatic logic [3:0] final_state(input op_class_e cls, input logic [4:0] op);
        case (cls)
            ClsR, ClsI, ClsLdi: final_state = StT5;
            ClsUn:              final_state = StT4;
            ClsMd, ClsBr:       final_state = StT6;
            ClsLd, ClsSt:       final_state = StT7;
            ClsJ:               final_state = (op == OpJal) ? StT5 : StT3;
            default:            final_state = StT3;
        endcase
    endfunction

endpackage

// File: rtl/mini_src_op_class.sv
// Groups a Mini-SRC opcode into the instruction class that selects its execute sequence.
module mini_src_op_class
    import mini_src_ctrl_pkg::*;
(
    input  logic [4:0] opcode_i,
    output op_class_e  op_class_o
);

    always_comb begin
        op_class_o = ClsNop;
        case (opcode_i)
            OpAdd, OpSub, OpAnd, OpOr, OpShr, OpShra, OpShl, OpRor, OpRol: op_class_o = ClsR;
            OpAddi, OpAndi, OpOri: op_class_o = ClsI;
            OpNeg, OpNot:          op_class_o = ClsUn;
            OpMul, OpDiv:          op_class_o = ClsMd;
            OpLd:                  op_class_o = ClsLd;
            OpLdi:                 op_class_o = ClsLdi;
            OpSt:                  op_class_o = ClsSt;
            OpBr:                  op_class_o = ClsBr;
            OpJr, OpJal:           op_class_o = ClsJ;
            OpIn, OpOut:           op_class_o = ClsIo;
            OpMfhi, OpMflo:        op_class_o = ClsMv;
            OpHalt:                op_class_o = ClsHlt;
            // Undefined opcodes fall through as nop.
            default:               op_class_o = ClsNop;
        endcase
    end

endmodule

// File: rtl/mini_src_control_unit.sv
// Hardwired Moore sequencer for the Mini-SRC datapath (RST, T0..T7, HALT).
// Define MINI_SRC_STOP_EN to add the Stop input that parks the sequencer between instructions.
module mini_src_control_unit
    import mini_src_ctrl_pkg::*;
#(
    parameter int unsigned CTRL_W = CtrlWidth,
    parameter int unsigned OP_W   = OpWidth
) (
    input  logic              clock,
    input  logic              clear_n,
`ifdef MINI_SRC_STOP_EN
    input  logic              Stop,
`endif
    input  logic [31:0]       IR,
    input  logic              CON_FF,
    output logic [CTRL_W-1:0] ctrl,
    output logic [OP_W-1:0]   alu_op,
    output logic              run,
    output logic [3:0]        state
);

    logic [3:0] state_q, state_d;
    logic [4:0] opcode;
    logic [4:0] alu_sel;
    op_class_e  op_class;
    logic       last_step;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];

    mini_src_op_class u_op_class (
        .opcode_i   (opcode),
        .op_class_o (op_class)
    );

    assign last_step = (state_q == final_state(op_class, opcode));

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRst: state_d = StT0;
            StT0:  state_d = StT1;
            StT1:  state_d = StT2;
            StT2:  state_d = StT3;
            StT3, StT4, StT5, StT6, StT7: begin
                if (!last_step) begin
                    state_d = state_q + 4'd1;
                end else if (op_class == ClsHlt) begin
                    state_d = StHalt;
`ifdef MINI_SRC_STOP_EN
                end else if (Stop) begin
                    state_d = StHalt;
`endif
                end else begin
                    state_d = StT0;
                end
            end
            StHalt: begin
`ifdef MINI_SRC_STOP_EN
                // IR still holds the halt opcode when parked by it, which keeps HALT sticky.
                if (!Stop && op_class != ClsHlt) state_d = StT0;
`endif
            end
            default: state_d = StRst;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= StRst;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ctrl    = '0;
        alu_sel = '0;
        case (state_q)
            StT0: begin
                ctrl[CPcOut] = 1'b1; ctrl[CMarIn] = 1'b1; ctrl[CIncPc] = 1'b1; ctrl[CPcIn] = 1'b1;
            end
            StT1: begin ctrl[CRead] = 1'b1; ctrl[CMdrIn] = 1'b1; end
            StT2: begin ctrl[CMdrOut] = 1'b1; ctrl[CIrIn] = 1'b1; end
            StT3: begin
                case (op_class)
                    ClsR, ClsI: begin ctrl[CGrb] = 1'b1; ctrl[CRout] = 1'b1; ctrl[CYin] = 1'b1; end
                    ClsUn: begin
                        ctrl[CGrb] = 1'b1; ctrl[CRout] = 1'b1; ctrl[CZlowIn] = 1'b1;
                        alu_sel = opcode;
                    end
                    ClsMd: begin ctrl[CGra] = 1'b1; ctrl[CRout] = 1'b1; ctrl[CYin] = 1'b1; end
                    ClsLd, ClsLdi, ClsSt: begin
                        ctrl[CGrb] = 1'b1; ctrl[CBaOut] = 1'b1; ctrl[CYin] = 1'b1;
                    end
                    ClsBr: begin ctrl[CGra] = 1'b1; ctrl[CRout] = 1'b1; ctrl[CConIn] = 1'b1; end
                    ClsJ: begin
                        // jal copies PC straight into Z; no ALU function is selected.
                        if (opcode == OpJal) begin
                            ctrl[CPcOut] = 1'b1; ctrl[CZlowIn] = 1'b1;
                        end else begin
                            ctrl[CGra] = 1'b1; ctrl[CRout] = 1'b1; ctrl[CPcIn] = 1'b1;
                        end
                    end
                    ClsIo: begin
                        ctrl[CGra] = 1'b1;
                        if (opcode == OpIn) begin
                            ctrl[CInPortOut] = 1'b1; ctrl[CRin] = 1'b1;
                        end else begin
                            ctrl[CRout] = 1'b1; ctrl[COutPortIn] = 1'b1;
                        end
                    end
                    ClsMv: begin
                        ctrl[CGra] = 1'b1; ctrl[CRin] = 1'b1;
                        if (opcode == OpMfhi) ctrl[CHiOut] = 1'b1;
                        else                  ctrl[CLoOut] = 1'b1;
                    end
                    default: ;
                endcase
            end
            StT4: begin
                case (op_class)
                    ClsR: begin
                        ctrl[CGrc] = 1'b1; ctrl[CRout] = 1'b1; ctrl[CZlowIn] = 1'b1;
                        alu_sel = opcode;
                    end
                    ClsI: begin ctrl[CCout] = 1'b1; ctrl[CZlowIn] = 1'b1; alu_sel = opcode; end
                    ClsUn: begin ctrl[CZlowOut] = 1'b1; ctrl[CGra] = 1'b1; ctrl[CRin] = 1'b1; end
                    ClsMd: begin
                        ctrl[CGrb] = 1'b1; ctrl[CRout] = 1'b1;
                        ctrl[CZhighIn] = 1'b1; ctrl[CZlowIn] = 1'b1;
                        alu_sel = opcode;
                    end
                    ClsLd, ClsLdi, ClsSt: begin
                        ctrl[CCout] = 1'b1; ctrl[CZlowIn] = 1'b1; alu_sel = OpAdd;
                    end
                    ClsBr: begin ctrl[CPcOut] = 1'b1; ctrl[CYin] = 1'b1; end
                    ClsJ: begin ctrl[CZlowOut] = 1'b1; ctrl[CJalFlag] = 1'b1; end
                    default: ;
                endcase
            end
            StT5: begin
                case (op_class)
                    ClsR, ClsI, ClsLdi: begin
                        ctrl[CZlowOut] = 1'b1; ctrl[CGra] = 1'b1; ctrl[CRin] = 1'b1;
                    end
                    ClsMd: begin ctrl[CZlowOut] = 1'b1; ctrl[CLoIn] = 1'b1; end
                    ClsLd, ClsSt: begin ctrl[CZlowOut] = 1'b1; ctrl[CMarIn] = 1'b1; end
                    ClsBr: begin ctrl[CCout] = 1'b1; ctrl[CZlowIn] = 1'b1; alu_sel = OpAdd; end
                    ClsJ: begin ctrl[CGra] = 1'b1; ctrl[CRout] = 1'b1; ctrl[CPcIn] = 1'b1; end
                    default: ;
                endcase
            end
            StT6: begin
                case (op_class)
                    ClsMd: begin ctrl[CZhighOut] = 1'b1; ctrl[CHiIn] = 1'b1; end
                    ClsLd: begin ctrl[CRead] = 1'b1; ctrl[CMdrIn] = 1'b1; end
                    ClsSt: begin ctrl[CGra] = 1'b1; ctrl[CRout] = 1'b1; ctrl[CMdrIn] = 1'b1; end
                    ClsBr: begin ctrl[CZlowOut] = CON_FF; ctrl[CPcIn] = CON_FF; end
                    default: ;
                endcase
            end
            StT7: begin
                case (op_class)
                    ClsLd: begin ctrl[CMdrOut] = 1'b1; ctrl[CGra] = 1'b1; ctrl[CRin] = 1'b1; end
                    ClsSt: ctrl[CWrite] = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign alu_op = OP_W'(alu_sel);
    assign run    = (state_q != StHalt);
    assign state  = state_q;

`ifndef SYNTHESIS
    bus_single_driver: assert property (@(posedge clock) disable iff (!clear_n)
        $onehot0(ctrl & CTRL_W'(BusDrivers)));
`endif

endmodule
